// File: rtl/horner_poly_eval_if.sv
// Bus bundle for horner_poly_eval: coefficient programming port plus the
// valid/ready sample input and result output handshakes.
interface horner_poly_eval_if #(
  parameter int DATA_WIDTH = 16,
  parameter int DEGREE     = 2,
  parameter int ADDR_WIDTH = $clog2(DEGREE + 1)
);
  logic                  coef_we;
  logic [ADDR_WIDTH-1:0] coef_addr;
  logic [DATA_WIDTH-1:0] coef_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] x;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] y;
  logic                  ovf;

  modport master (
    output coef_we, coef_addr, coef_data, in_valid, x, out_ready,
    input  in_ready, out_valid, y, ovf
  );

  modport slave (
    input  coef_we, coef_addr, coef_data, in_valid, x, out_ready,
    output in_ready, out_valid, y, ovf
  );
endinterface

// File: rtl/horner_poly_eval.sv
// Iterative Horner-rule polynomial evaluator with a programmable coefficient
// bank and a single shared multiply-add; result is modulo 2^DATA_WIDTH.
module horner_poly_eval #(
  parameter int DATA_WIDTH = 16,
  parameter int DEGREE     = 2,
  parameter int ADDR_WIDTH = $clog2(DEGREE + 1)
) (
  input logic               clk,
  input logic               rst,
  horner_poly_eval_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                state;
  state_t                state_nxt;
  logic                  in_ready_c;
  logic                  out_valid_c;
  logic                  accept;
  logic                  coef_wr_ok;
  logic                  last_step;

  logic [DATA_WIDTH-1:0] coef [0:DEGREE];
  logic [DATA_WIDTH-1:0] x_reg;
  logic [DATA_WIDTH-1:0] acc;
  logic [ADDR_WIDTH-1:0] step;
  logic                  ovf_int;
  logic [DATA_WIDTH-1:0] y_reg;
  logic                  ovf_reg;

  logic [DATA_WIDTH:0]   mac_res;
  logic [DATA_WIDTH-1:0] mac_sum;
  logic                  mac_ovf;

  // One Horner step: {overflow, (a*xv + c) mod 2^DATA_WIDTH}. Overflow flags a
  // product that does not fit DATA_WIDTH bits or a carry out of the addition.
  function automatic logic [DATA_WIDTH:0] mac_step(
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] xv,
    input logic [DATA_WIDTH-1:0] c
  );
    logic [2*DATA_WIDTH-1:0] prod;
    logic [DATA_WIDTH:0]     sum;
    prod = {{DATA_WIDTH{1'b0}}, a} * {{DATA_WIDTH{1'b0}}, xv};
    sum  = {1'b0, prod[DATA_WIDTH-1:0]} + {1'b0, c};
    return {(|prod[2*DATA_WIDTH-1:DATA_WIDTH]) | sum[DATA_WIDTH],
            sum[DATA_WIDTH-1:0]};
  endfunction

  assign mac_res    = mac_step(acc, x_reg, coef[step]);
  assign mac_sum    = mac_res[DATA_WIDTH-1:0];
  assign mac_ovf    = mac_res[DATA_WIDTH];
  assign last_step  = (step == '0);
  assign accept     = bus.in_valid && in_ready_c;
  assign coef_wr_ok = bus.coef_we && (state == IDLE) &&
                      (bus.coef_addr <= ADDR_WIDTH'(DEGREE));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)        state_nxt = CALC;
      CALC:    if (last_step)     state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // A coefficient write in the same cycle blocks acceptance so a sample never
  // sees a half-updated bank.
  always_comb begin
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state)
      IDLE:    in_ready_c  = !bus.coef_we;
      DONE:    out_valid_c = 1'b1;
      default: ;
    endcase
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.y         = y_reg;
  assign bus.ovf       = ovf_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k <= DEGREE; k++) coef[k] <= '0;
    end else if (coef_wr_ok) begin
      coef[bus.coef_addr] <= bus.coef_data;
    end
  end

  // Accept loads the leading coefficient; each CALC cycle folds in the next
  // lower one until step 0 publishes the result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_reg   <= '0;
      acc     <= '0;
      step    <= '0;
      ovf_int <= 1'b0;
      y_reg   <= '0;
      ovf_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            x_reg   <= bus.x;
            acc     <= coef[DEGREE];
            step    <= ADDR_WIDTH'(DEGREE - 1);
            ovf_int <= 1'b0;
          end
        end
        CALC: begin
          acc     <= mac_sum;
          ovf_int <= ovf_int | mac_ovf;
          if (last_step) begin
            y_reg   <= mac_sum;
            ovf_reg <= ovf_int | mac_ovf;
          end else begin
            step <= step - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_horner_poly_eval.sv
// Scoreboard bench for horner_poly_eval: DEGREE=2 and DEGREE=1 instances,
// directed vectors with hand-computed results.
module tb_horner_poly_eval;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  horner_poly_eval_if #(.DATA_WIDTH(DW), .DEGREE(2)) b2 ();
  horner_poly_eval_if #(.DATA_WIDTH(DW), .DEGREE(1)) b1 ();

  horner_poly_eval #(.DATA_WIDTH(DW), .DEGREE(2)) dut2 (
    .clk(clk), .rst(rst), .bus(b2.slave));
  horner_poly_eval #(.DATA_WIDTH(DW), .DEGREE(1)) dut1 (
    .clk(clk), .rst(rst), .bus(b1.slave));

  typedef struct {
    logic [DW-1:0] y;
    logic          ovf;
  } exp_t;

  exp_t q2[$];
  exp_t q1[$];
  int   a2[$];
  int   a1[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitors: record accepts, check first-valid latency, pop and compare on
  // every output handshake.
  logic pv2 = 1'b0;
  always @(negedge clk) begin : mon2
    exp_t e;
    if (rst) begin
      if (b2.in_valid && b2.in_ready) a2.push_back(cyc);
      if (b2.out_valid && !pv2) begin
        if (a2.size() == 0) chk("latency2_no_accept", 1, 0);
        else chk("latency2", cyc - a2.pop_front() - 1, 2);
      end
      if (b2.out_valid && b2.out_ready) begin
        if (q2.size() == 0) chk("unexpected_out2", 1, 0);
        else begin
          e = q2.pop_front();
          chk("y2", int'(b2.y), int'(e.y));
          chk("ovf2", int'(b2.ovf), int'(e.ovf));
        end
      end
    end
    pv2 = b2.out_valid;
  end

  logic pv1 = 1'b0;
  always @(negedge clk) begin : mon1
    exp_t e;
    if (rst) begin
      if (b1.in_valid && b1.in_ready) a1.push_back(cyc);
      if (b1.out_valid && !pv1) begin
        if (a1.size() == 0) chk("latency1_no_accept", 1, 0);
        else chk("latency1", cyc - a1.pop_front() - 1, 1);
      end
      if (b1.out_valid && b1.out_ready) begin
        if (q1.size() == 0) chk("unexpected_out1", 1, 0);
        else begin
          e = q1.pop_front();
          chk("y1", int'(b1.y), int'(e.y));
          chk("ovf1", int'(b1.ovf), int'(e.ovf));
        end
      end
    end
    pv1 = b1.out_valid;
  end

  task automatic wr2(input int addr, input int data);
    @(posedge clk); #1;
    b2.coef_we = 1'b1; b2.coef_addr = 2'(addr); b2.coef_data = DW'(data);
    @(posedge clk); #1;
    b2.coef_we = 1'b0;
  endtask

  task automatic wr1(input int addr, input int data);
    @(posedge clk); #1;
    b1.coef_we = 1'b1; b1.coef_addr = 1'(addr); b1.coef_data = DW'(data);
    @(posedge clk); #1;
    b1.coef_we = 1'b0;
  endtask

  // Returns just after the accept edge; x is then scrambled to show it is not reused.
  task automatic send2(input int xv, input int ey, input int eovf, input bit expect_out);
    int n;
    @(posedge clk); #1;
    b2.x = DW'(xv); b2.in_valid = 1'b1;
    if (expect_out) q2.push_back('{DW'(ey), 1'(eovf)});
    n = 0;
    forever begin
      @(negedge clk);
      if (b2.in_ready) break;
      if (++n > 50) begin chk("accept_timeout2", 1, 0); break; end
    end
    @(posedge clk); #1;
    b2.in_valid = 1'b0; b2.x = '1;
  endtask

  task automatic send1(input int xv, input int ey, input int eovf, output int acc_cyc);
    int n;
    @(posedge clk); #1;
    b1.x = DW'(xv); b1.in_valid = 1'b1;
    q1.push_back('{DW'(ey), 1'(eovf)});
    n = 0;
    acc_cyc = -1;
    forever begin
      @(negedge clk);
      if (b1.in_ready) begin acc_cyc = cyc; break; end
      if (++n > 50) begin chk("accept_timeout1", 1, 0); break; end
    end
    @(posedge clk); #1;
    b1.in_valid = 1'b0; b1.x = '1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (q2.size() == 0 && q1.size() == 0 && b2.in_ready && b1.in_ready &&
          !b2.out_valid && !b1.out_valid) break;
      if (++n > 100) begin chk(name, 1, 0); break; end
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n, t1, t2;
    rst = 1'b0;
    b2.coef_we = 0; b2.coef_addr = '0; b2.coef_data = '0;
    b2.in_valid = 0; b2.x = '0; b2.out_ready = 1'b1;
    b1.coef_we = 0; b1.coef_addr = '0; b1.coef_data = '0;
    b1.in_valid = 0; b1.x = '0; b1.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", int'(b2.out_valid), 0);
    chk("rst_y", int'(b2.y), 0);
    chk("rst_ovf", int'(b2.ovf), 0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", int'(b2.in_ready), 1);

    // (2x+4)x+6; address 3 lies beyond the bank and must be ignored
    wr2(2, 2); wr2(1, 4); wr2(0, 6); wr2(3, 999);
    send2(3, 36, 0, 1);       drain("drain_basic");
    send2(300, 50134, 1, 1);  drain("drain_ovf");
    send2(3, 36, 0, 1);       drain("drain_ovf_clear");

    // Backpressure
    @(posedge clk); #1 b2.out_ready = 1'b0;
    send2(3, 36, 0, 1);
    n = 0;
    forever begin
      @(negedge clk);
      if (b2.out_valid) break;
      if (++n > 20) begin chk("out_valid_timeout", 1, 0); break; end
    end
    repeat (10) begin
      chk("bp_y", int'(b2.y), 36);
      chk("bp_in_ready", int'(b2.in_ready), 0);
      @(negedge clk);
    end
    @(posedge clk); #1 b2.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("in_ready_after_hs", int'(b2.in_ready), 1);
    drain("drain_bp");

    // Coefficient write during CALC is ignored
    send2(3, 36, 0, 1);
    b2.coef_we = 1'b1; b2.coef_addr = 2'd0; b2.coef_data = 16'd100;
    @(posedge clk); #1 b2.coef_we = 1'b0;
    drain("drain_calc_write");
    wr2(0, 100);
    send2(3, 130, 0, 1);      drain("drain_idle_write");

    // in_valid together with coef_we: no accept
    @(posedge clk); #1;
    b2.coef_we = 1'b1; b2.coef_addr = 2'd0; b2.coef_data = 16'd100;
    b2.in_valid = 1'b1; b2.x = 16'd3;
    @(negedge clk);
    chk("in_ready_during_we", int'(b2.in_ready), 0);
    @(posedge clk); #1;
    b2.coef_we = 1'b0; b2.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("no_accept_out_valid", int'(b2.out_valid), 0);
    chk("no_accept_in_ready", int'(b2.in_ready), 1);

    // Reset mid-CALC
    send2(3, 0, 0, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", int'(b2.out_valid), 0);
    chk("midrst_y", int'(b2.y), 0);
    chk("midrst_ovf", int'(b2.ovf), 0);
    a2.delete(); q2.delete();
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", int'(b2.in_ready), 1);
    send2(5, 0, 0, 1);        drain("drain_cleared");

    // DEGREE=1: 7x+1, back-to-back
    wr1(1, 7); wr1(0, 1);
    send1(2, 15, 0, t1);
    send1(4, 29, 0, t2);
    chk("issue_interval1", t2 - t1, 3);
    drain("drain_deg1");

    chk("scoreboard_empty", q2.size() + q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
